// File: rtl/btn_sw_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_sw_conditioner_if
// Purpose  : Raw button/switch inputs and conditioned outputs of the
//            button/switch front end, bundled for the LED pattern datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface btn_sw_conditioner_if;
  logic [3:0] btn;          // raw push buttons, asynchronous to the clock
  logic [1:0] sw;           // raw slide switches, asynchronous to the clock
  logic [3:0] btn_db;       // debounced button levels
  logic [3:0] btn_press;    // one-cycle pulse per debounced 0->1 transition
  logic [1:0] sw_db;        // debounced switch levels
  logic [1:0] mode_sel;     // latched mode select
  logic       mode_change;  // one-cycle pulse when mode_sel is loaded

  // Board / consumer side: supplies raw pins, observes conditioned outputs
  modport master (
    output btn, sw,
    input  btn_db, btn_press, sw_db, mode_sel, mode_change
  );

  // Conditioner side
  modport slave (
    input  btn, sw,
    output btn_db, btn_press, sw_db, mode_sel, mode_change
  );
endinterface
`default_nettype wire

// File: rtl/btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_sw_conditioner
// Purpose  : Synchronizes and debounces raw buttons/switches, generates press
//            pulses and a latched 2-bit mode select from the last press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1250000,  // >= 2
  parameter int CNT_W           = 21        // must hold DEBOUNCE_CYCLES-1
) (
  input  wire logic           clk_125,
  input  wire logic           sys_rst,
  btn_sw_conditioner_if.slave cond_if
);

  // Buttons occupy bits [3:0], switches bits [5:4].
  localparam int NB = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {M0 = 2'd0, M1 = 2'd1, M2 = 2'd2, M3 = 2'd3} mode_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] db;
  logic [3:0]    btn_db_dly_q;
  logic [3:0]    press;
  mode_t         mode_q;
  logic          mode_change_q;

  assign raw = {cond_if.sw, cond_if.btn};

  // Two-flop synchronizer, no logic between the stages
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // Count consecutive disagreements; any agreement restarts the count and
    // the value is accepted on the cycle the count would reach DEBOUNCE_CYCLES
    always_ff @(posedge clk_125) begin
      if (sys_rst) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync2_q[i] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign db[i] = db_q;
  end

  // Previous debounced button levels for rising-edge detection
  always_ff @(posedge clk_125) begin
    if (sys_rst) btn_db_dly_q <= '0;
    else         btn_db_dly_q <= db[3:0];
  end

  assign press = db[3:0] & ~btn_db_dly_q;

  // Mode FSM: highest-index new press wins; re-selecting the current mode
  // still pulses mode_change
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      mode_q        <= M0;
      mode_change_q <= 1'b0;
    end else if (|press) begin
      mode_change_q <= 1'b1;
      if      (press[3]) mode_q <= M3;
      else if (press[2]) mode_q <= M2;
      else if (press[1]) mode_q <= M1;
      else               mode_q <= M0;
    end else begin
      mode_change_q <= 1'b0;
    end
  end

  assign cond_if.btn_db      = db[3:0];
  assign cond_if.sw_db       = db[5:4];
  assign cond_if.btn_press   = press;
  assign cond_if.mode_sel    = mode_q;
  assign cond_if.mode_change = mode_change_q;

endmodule
`default_nettype wire
